// File: rtl/line_fill_server.sv
// line_fill_server: memory-side refill responder that assembles a cache line from a word RAM
// and returns it after a programmable latency. Optional range checking: LINE_FILL_SRV_RANGE_CHECK_EN.
module line_fill_server #(
   parameter int ADDR_WIDTH  = 32,
   parameter int LINE_BYTES  = 16,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    mem_req,
   input  logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic                    mem_rvalid,
   output logic [LINE_BYTES*8-1:0] mem_rdata,
   input  logic                    init_we,
   input  logic [ADDR_WIDTH-1:0]   init_addr,
   input  logic [31:0]             init_wdata,
`ifdef LINE_FILL_SRV_RANGE_CHECK_EN
   output logic                    mem_err,
`endif
   output logic                    busy
);

   localparam int W         = LINE_BYTES / 4;
   localparam int IDX_BITS  = $clog2(DEPTH_WORDS);
   localparam int BEAT_BITS = (W > 1) ? $clog2(W) : 1;
   localparam int LAT_BITS  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int LAT_LAST  = (LATENCY > 0) ? LATENCY - 1 : 0;

   localparam logic [IDX_BITS-1:0]  LINE_MASK = IDX_BITS'(W - 1);
   localparam logic [BEAT_BITS-1:0] BEAT_LAST = BEAT_BITS'(W - 1);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WAIT,
      RESP
   } state_t;

   state_t state;
   state_t state_next;

   logic [BEAT_BITS-1:0]    beat;
   logic [LAT_BITS-1:0]     lat_cnt;
   logic [IDX_BITS-1:0]     base_idx;
   logic                    oor_q;

   logic [31:0]             ram [DEPTH_WORDS];
   logic [31:0]             line_buf [W];
   logic [LINE_BYTES*8-1:0] line_flat;

   logic [IDX_BITS-1:0]     req_idx;
   logic [IDX_BITS-1:0]     init_idx;
   logic [IDX_BITS-1:0]     fetch_idx;
   logic                    req_oor;
   logic                    init_ok;

   logic                    accept;
   logic                    fetch_en;
   logic                    wait_en;
   logic                    resp_en;
   logic                    last_beat;
   logic                    lat_done;

   // Low byte-offset bits never select a word; upper bits only matter to the range check.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{mem_addr[1:0], mem_addr[ADDR_WIDTH-1:2+IDX_BITS],
                               init_addr[1:0], init_addr[ADDR_WIDTH-1:2+IDX_BITS]};

   assign req_idx   = mem_addr[2 +: IDX_BITS] & ~LINE_MASK;
   assign init_idx  = init_addr[2 +: IDX_BITS];
   assign fetch_idx = base_idx + IDX_BITS'(beat);

`ifdef LINE_FILL_SRV_RANGE_CHECK_EN
   assign req_oor = |mem_addr[ADDR_WIDTH-1:2+IDX_BITS];
   assign init_ok = init_we && !(|init_addr[ADDR_WIDTH-1:2+IDX_BITS]);
`else
   assign req_oor = 1'b0;
   assign init_ok = init_we;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (mem_req) state_next = FETCH;
         FETCH:   if (last_beat) state_next = (LATENCY == 0) ? RESP : WAIT;
         WAIT:    if (lat_done) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      accept    = (state == IDLE) && mem_req;
      fetch_en  = (state == FETCH);
      wait_en   = (state == WAIT);
      resp_en   = (state == RESP);
      last_beat = fetch_en && (beat == BEAT_LAST);
      lat_done  = wait_en && (lat_cnt == LAT_BITS'(LAT_LAST));
   end

   // The beat counter returns to zero on the last beat so it never indexes past the line.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         beat       <= '0;
         lat_cnt    <= '0;
         base_idx   <= '0;
         oor_q      <= 1'b0;
         busy       <= 1'b0;
         mem_rvalid <= 1'b0;
         mem_rdata  <= '0;
         for (int k = 0; k < W; k++) begin
            line_buf[k] <= '0;
         end
      end else begin
         mem_rvalid <= 1'b0;
         if (accept) begin
            base_idx <= req_idx;
            oor_q    <= req_oor;
            beat     <= '0;
            lat_cnt  <= '0;
            busy     <= 1'b1;
         end
         if (fetch_en) begin
            line_buf[beat] <= ram[fetch_idx];
            beat           <= last_beat ? '0 : beat + 1'b1;
         end
         if (wait_en) begin
            lat_cnt <= lat_done ? '0 : lat_cnt + 1'b1;
         end
         if (resp_en) begin
            mem_rdata  <= oor_q ? '0 : line_flat;
            mem_rvalid <= 1'b1;
            busy       <= 1'b0;
         end
      end
   end

`ifdef LINE_FILL_SRV_RANGE_CHECK_EN
   always_ff @(posedge clk) begin
      if (!rstn) begin
         mem_err <= 1'b0;
      end else begin
         mem_err <= resp_en && oor_q;
      end
   end
`endif

   always_comb begin
      line_flat = '0;
      for (int k = 0; k < W; k++) begin
         line_flat[k*32 +: 32] = line_buf[k];
      end
   end

   // Backing store keeps its contents through reset; a same-edge fetch sees the old word.
   always_ff @(posedge clk) begin
      if (init_ok) begin
         ram[init_idx] <= init_wdata;
      end
   end

endmodule

// File: tb/tb_line_fill_server.sv
// tb_line_fill_server: directed and randomized refill checks against a word-array model,
// with a second LATENCY=0 instance sharing the clock, reset and init port.
module tb_line_fill_server;

   localparam int AW         = 32;
   localparam int LINE_BYTES = 16;
   localparam int LINE_W     = LINE_BYTES / 4;
   localparam int DEPTH      = 1024;
   localparam int LAT        = 2;
   localparam int EXP_LAT    = LINE_W + LAT + 1;
   localparam int EXP_LAT0   = LINE_W + 0 + 1;
   localparam int BUDGET     = 50;

   logic                    clk = 1'b0;
   logic                    rstn;
   logic                    mem_req;
   logic [AW-1:0]           mem_addr;
   logic                    mem_rvalid;
   logic [LINE_BYTES*8-1:0] mem_rdata;
   logic                    busy;
   logic                    init_we;
   logic [AW-1:0]           init_addr;
   logic [31:0]             init_wdata;
   logic                    req0;
   logic [AW-1:0]           addr0;
   logic                    rvalid0;
   logic [LINE_BYTES*8-1:0] rdata0;
   logic                    busy0;
`ifdef LINE_FILL_SRV_RANGE_CHECK_EN
   logic                    mem_err;
   logic                    err0;
`endif

   int total = 0;
   int bad   = 0;

   logic [31:0] model_ram [DEPTH];

   always #5 clk = ~clk;

   line_fill_server #(
      .ADDR_WIDTH(AW), .LINE_BYTES(LINE_BYTES), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)
   ) dut (
      .clk(clk), .rstn(rstn), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata),
`ifdef LINE_FILL_SRV_RANGE_CHECK_EN
      .mem_err(mem_err),
`endif
      .busy(busy)
   );

   line_fill_server #(
      .ADDR_WIDTH(AW), .LINE_BYTES(LINE_BYTES), .DEPTH_WORDS(DEPTH), .LATENCY(0)
   ) dut0 (
      .clk(clk), .rstn(rstn), .mem_req(req0), .mem_addr(addr0),
      .mem_rvalid(rvalid0), .mem_rdata(rdata0),
      .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata),
`ifdef LINE_FILL_SRV_RANGE_CHECK_EN
      .mem_err(err0),
`endif
      .busy(busy0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int wordIndex(input logic [31:0] addr);
      return int'((addr / 32'd4) % 32'(DEPTH));
   endfunction

   function automatic logic [127:0] modelLine(input logic [31:0] addr);
      logic [127:0] line;
      int           baseWord;
      baseWord = wordIndex(addr - (addr % 32'(LINE_BYTES)));
      for (int k = 0; k < LINE_W; k++) begin
         line[k*32 +: 32] = model_ram[(baseWord + k) % DEPTH];
      end
      return line;
   endfunction

   task automatic modelWrite(input logic [31:0] addr, input logic [31:0] data);
`ifdef LINE_FILL_SRV_RANGE_CHECK_EN
      if (addr < 32'(DEPTH * 4)) model_ram[wordIndex(addr)] = data;
`else
      model_ram[wordIndex(addr)] = data;
`endif
   endtask

   task automatic preloadWord(input logic [31:0] addr, input logic [31:0] data);
      init_we    = 1'b1;
      init_addr  = addr;
      init_wdata = data;
      tick();
      init_we = 1'b0;
      modelWrite(addr, data);
   endtask

   // One refill on the main instance; optional extra requests and one init write at given edge offsets.
   task automatic applyStimulus(input string tag, input logic [31:0] addr, input int spamA,
                                input int spamB, input int hitAt, input logic [31:0] hitAddr,
                                input logic [31:0] hitData);
      logic [127:0] exp;
      int           k;
      int           lowBusy;
      int           extra;
      exp = modelLine(addr);
`ifdef LINE_FILL_SRV_RANGE_CHECK_EN
      if (addr >= 32'(DEPTH * 4)) exp = '0;
`endif
      mem_req  = 1'b1;
      mem_addr = addr;
      tick();
      mem_req = 1'b0;
      checkOutput({tag, " busy_at_accept"}, 128'(busy), 128'(1'b1));
      k       = 0;
      lowBusy = 0;
      while (mem_rvalid !== 1'b1 && k < BUDGET) begin
         if (busy !== 1'b1) lowBusy++;
         if (k + 1 == spamA || k + 1 == spamB) begin
            mem_req  = 1'b1;
            mem_addr = addr ^ 32'h80;
         end
         if (k + 1 == hitAt) begin
            init_we    = 1'b1;
            init_addr  = hitAddr;
            init_wdata = hitData;
         end
         tick();
         k++;
         mem_req = 1'b0;
         if (init_we) begin
            init_we = 1'b0;
            modelWrite(hitAddr, hitData);
         end
      end
      checkOutput({tag, " latency"}, 128'(k), 128'(EXP_LAT));
      checkOutput({tag, " busy_while_pending"}, 128'(lowBusy), 128'(0));
      checkOutput({tag, " rdata"}, mem_rdata, exp);
      checkOutput({tag, " busy_at_rvalid"}, 128'(busy), 128'(1'b0));
`ifdef LINE_FILL_SRV_RANGE_CHECK_EN
      checkOutput({tag, " err"}, 128'(mem_err), 128'(addr >= 32'(DEPTH * 4)));
`endif
      tick();
      checkOutput({tag, " rvalid_one_cycle"}, 128'(mem_rvalid), 128'(1'b0));
      checkOutput({tag, " rdata_hold"}, mem_rdata, exp);
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (mem_rvalid === 1'b1) extra++;
      end
      checkOutput({tag, " extra_pulses"}, 128'(extra), 128'(0));
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int k;
      int extra;

      rstn       = 1'b0;
      mem_req    = 1'b0;
      mem_addr   = '0;
      init_we    = 1'b0;
      init_addr  = '0;
      init_wdata = '0;
      req0       = 1'b0;
      addr0      = '0;
      tick();
      tick();
      checkOutput("reset rvalid", 128'(mem_rvalid), 128'(1'b0));
      checkOutput("reset rdata", mem_rdata, 128'(0));
      checkOutput("reset busy", 128'(busy), 128'(1'b0));
      checkOutput("reset busy0", 128'(busy0), 128'(1'b0));
      rstn = 1'b1;
      tick();

      for (int i = 0; i < 64; i++) begin
         if (i >= 16 && i < 20) preloadWord(32'(i * 4), 32'h11111111 * 32'(i - 15));
         else preloadWord(32'(i * 4), $urandom());
      end

      applyStimulus("basic", 32'h44, -1, -1, -1, 32'h0, 32'h0);
      checkOutput("basic const", mem_rdata, 128'h44444444_33333333_22222222_11111111);

      applyStimulus("spam", 32'h80, 2, 4, -1, 32'h0, 32'h0);
      applyStimulus("spam_resp", 32'hC0, EXP_LAT, -1, -1, 32'h0, 32'h0);

      applyStimulus("collide", 32'h40, -1, -1, 3, 32'h48, 32'h55555555);
      checkOutput("collide old word2", 128'(mem_rdata[95:64]), 128'(32'h33333333));
      applyStimulus("after_collide", 32'h40, -1, -1, -1, 32'h0, 32'h0);
      checkOutput("after_collide new word2", 128'(mem_rdata[95:64]), 128'(32'h55555555));

      // Abandon a refill while it is waiting out its latency.
      mem_req  = 1'b1;
      mem_addr = 32'h40;
      tick();
      mem_req = 1'b0;
      repeat (5) tick();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      checkOutput("midreset rvalid", 128'(mem_rvalid), 128'(1'b0));
      checkOutput("midreset rdata", mem_rdata, 128'(0));
      checkOutput("midreset busy", 128'(busy), 128'(1'b0));
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (mem_rvalid === 1'b1) extra++;
      end
      checkOutput("midreset no_rvalid", 128'(extra), 128'(0));
      applyStimulus("post_reset", 32'h40, -1, -1, -1, 32'h0, 32'h0);

      for (int i = 0; i < 6; i++) begin
         applyStimulus("rand", 32'($urandom_range(0, 255)), -1, -1, -1, 32'h0, 32'h0);
      end

      applyStimulus("range", 32'h1000, -1, -1, -1, 32'h0, 32'h0);
      preloadWord(32'h1000, 32'hA5A50001);
      applyStimulus("range_init", 32'h0, -1, -1, -1, 32'h0, 32'h0);

      req0  = 1'b1;
      addr0 = 32'h40;
      tick();
      req0 = 1'b0;
      k    = 0;
      while (rvalid0 !== 1'b1 && k < BUDGET) begin
         tick();
         k++;
      end
      checkOutput("lat0 latency", 128'(k), 128'(EXP_LAT0));
      checkOutput("lat0 rdata", rdata0, modelLine(32'h40));
      checkOutput("lat0 busy_at_rvalid", 128'(busy0), 128'(1'b0));
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (rvalid0 === 1'b1) extra++;
      end
      checkOutput("lat0 single_pulse", 128'(extra), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/line_fill_server.md
Name: line_fill_server

Overview:
- Memory-side responder for the instruction cache's line-refill interface.
- Accepts a one-cycle mem_req pulse carrying a line-aligned byte address.
- Assembles the full line from a word-wide internal backing RAM, one word per cycle, then waits a programmable latency.
- Returns the line with a one-cycle mem_rvalid pulse. A word-write init port preloads program images.

Parameters:
- ADDR_WIDTH, 32, byte-address width shared with the cache.
- LINE_BYTES, 16, line size in bytes; power of two, >= 4.
- DEPTH_WORDS, 1024, backing RAM depth in 32-bit words; power of two.
- LATENCY, 2, extra wait cycles after line assembly; 0 is legal.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- mem_req  in  1  refill request pulse from the cache.
- mem_addr  in  ADDR_WIDTH  line byte address, sampled with mem_req.
- mem_rvalid  out  1  one-cycle line-valid pulse.
- mem_rdata  out  LINE_BYTES*8  returned line; word k occupies bits [32k+31:32k].
- init_we  in  1  preload word write enable.
- init_addr  in  ADDR_WIDTH  preload byte address; bits [1:0] ignored.
- init_wdata  in  32  preload data.
- busy  out  1  high from the accept edge until the mem_rvalid edge.

Behaviour:
- Reset is synchronous, active-low, with one clock.
  - rstn low at a rising edge: state goes to IDLE; mem_rvalid=0, mem_rdata=0, busy=0; beat and latency counters and the line buffer clear.
  - Backing RAM contents are NOT reset.
  - Reset mid-operation abandons the refill; no mem_rvalid follows.
- Derived values:
  - W = LINE_BYTES/4.
  - OFFSET_BITS = log2(LINE_BYTES).
  - Word index = addr[2 +: log2(DEPTH_WORDS)]; higher bits are ignored, so addresses wrap modulo the RAM size.
- Accepted request address: mem_addr bits [OFFSET_BITS-1:0] are forced to 0.
- States: IDLE, FETCH, WAIT, RESP.
  - IDLE: on mem_req at edge E0, latch the line base, clear beat=0, busy=1, go to FETCH.
  - FETCH: each edge, copy RAM[base_word+beat] into buffer word[beat] and increment beat. After the edge that stores beat W-1, go to WAIT, or to RESP if LATENCY=0.
  - WAIT: count LATENCY edges, then go to RESP.
  - RESP: on this edge, load mem_rdata from the buffer, set mem_rvalid=1 and busy=0, return to IDLE.
- Latency: mem_rvalid is high in exactly one cycle, starting at edge E0+W+LATENCY+1. Defaults give 7 cycles.
- mem_rdata holds its value after the mem_rvalid pulse until the next response.
- mem_rvalid is forced 0 on every edge other than the RESP edge.
- mem_req while busy (FETCH/WAIT/RESP) is ignored: no queueing, no side effect. mem_req at the same edge the RESP edge fires is also ignored.
- Init port:
  - init_we writes RAM[word index of init_addr] at the edge, in any state.
  - Same-edge init write and FETCH read of the same word: FETCH captures the old value (read-before-write).
- The beat counter wraps only through the state transition; it never indexes past W-1.

Optional Feature:
- Macro: LINE_FILL_SRV_RANGE_CHECK_EN.
- Defined:
  - Adds output mem_err (1 bit, reset 0).
  - A request with any mem_addr bit above (2+log2(DEPTH_WORDS)-1) set is flagged out of range.
  - The full timing sequence still runs, but the returned line is all zeros.
  - mem_err pulses high in the same cycle as mem_rvalid.
  - Out-of-range init writes are dropped.
- Undefined: no mem_err port; out-of-range addresses wrap as above.

Test Plan:
- Reset then request: preload words 0..3 at byte addrs 0x40..0x4C with 0x11111111, 0x22222222, 0x33333333, 0x44444444; mem_req with mem_addr=0x44 -> mem_rvalid high exactly 7 cycles after the request edge, mem_rdata=0x44444444_33333333_22222222_11111111, busy low the same cycle.
- LATENCY=0 build: request to 0x40 -> mem_rvalid at E0+5; mem_rvalid pulses only once.
- Second mem_req pulses issued 2 and 4 cycles after the first while busy -> exactly one mem_rvalid, with data from the first address.
- During FETCH of line 0x40, init write 0x55555555 to 0x48 on the edge that reads beat 2 -> response word 2 = 0x33333333. A following request to 0x40 returns word 2 = 0x55555555.
- Assert rstn low for 1 cycle during WAIT -> no mem_rvalid; mem_rdata=0, busy=0. A new request to 0x40 afterwards returns the preloaded line intact.
- RANGE_CHECK_EN with DEPTH_WORDS=1024: request to 0x0000_1000 -> mem_rvalid and mem_err both high at E0+7, mem_rdata=0. Without the macro, the same request returns the line at 0x0 (wrap).
